// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V core and its fetch front end.
//   - base opcode constants
//   - end-of-program marker word
//   - core stage encoding (IF..WB)
//   - prefetch state encoding (RUN/HALT/FAULT)
//   - prefetch queue entry layout {fault, pc, instr}
package riscv_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0000011;  // loads
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_U     = 7'b0110111;  // lui
  localparam logic [6:0] OP_J     = 7'b1101111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [31:0] EOF_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IF, ST_ID, ST_EX, ST_MEM, ST_WB
  } core_stage_e;

  typedef enum logic [1:0] {
    F_RUN, F_HALT, F_FAULT
  } fetch_state_e;

  typedef struct packed {
    logic        fault;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/ifetch_queue_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of prefetch entries.
//   clk, rst     clock, async active-high reset
//   flush        drop all entries (wins over push)
//   push, wdata  enqueue (ignored when full)
//   pop          dequeue head (ignored when empty)
//   rdata        head entry, straight from storage
//   count        current occupancy, full/empty flags
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       wdata,
  input  logic                     pop,
  output logic [ENTRY_W-1:0]       rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][ENTRY_W-1:0] mem;
  logic [AW-1:0]                 wr_ptr, rd_ptr;
  logic                          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Collapse onto the current head so the head word is left untouched.
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction prefetcher in front of the core.
// Walks fetch_pc through a 1-cycle-latency instruction RAM, buffers
// {fault, pc, instr} in a small FIFO and hands entries over valid/ready.
//   CLOCK_50, reset              clock, async active-high reset
//   imem_req/imem_index          RAM read strobe and word index
//   imem_rdata                   RAM data, one cycle after imem_req
//   instr_valid/ready, instr,
//   instr_pc, instr_fault        head-of-queue handshake to the core
//   redirect_valid/redirect_pc   fetch restart from branch resolution
//   halted                       fetch stopped on EOF or fault
//   fetch_count                  entries accepted by the core (saturating)
module ifetch_queue
  import riscv_pkg::fetch_state_e, riscv_pkg::F_RUN, riscv_pkg::F_HALT,
         riscv_pkg::F_FAULT, riscv_pkg::ENTRY_W;
#(
  parameter int          DEPTH      = 4,
  parameter int          IMEM_WORDS = 35,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EOF_WORD   = riscv_pkg::EOF_WORD
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_index,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

  fetch_state_e        state;
  logic [31:0]         fetch_pc, req_pc;
  logic                inflight, req_live, req_epoch, epoch;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]  head, wentry;
  logic                slot_free, pc_bad, can_go, issue, fault_enq;
  logic                resp_live, resp_eof, push, pop;

  // Occupancy counts the outstanding RAM read so a response always has room.
  assign slot_free = !fifo_full && ((32'(fifo_count) + 32'(inflight)) < 32'(DEPTH));
  assign pc_bad    = (fetch_pc >= PC_LIMIT) || (fetch_pc[1:0] != 2'b00);
  assign can_go    = !reset && (state == F_RUN) && !redirect_valid && slot_free;
  assign issue     = can_go && !pc_bad;
  // A bad PC never touches RAM; it becomes a synthetic EOF once no response
  // is pending, so it never competes with a RAM response for the write port.
  assign fault_enq = can_go && pc_bad && !inflight;

  assign resp_live = inflight && req_live && (req_epoch == epoch) && !redirect_valid;
  assign resp_eof  = resp_live && (imem_rdata == EOF_WORD);
  assign push      = resp_live || fault_enq;
  assign wentry    = fault_enq ? {1'b1, fetch_pc, EOF_WORD} : {1'b0, req_pc, imem_rdata};
  assign pop       = !fifo_empty && instr_ready;

  assign imem_req    = issue;
  assign imem_index  = {2'b00, fetch_pc[31:2]};
  assign instr_valid = !fifo_empty;
  assign {instr_fault, instr_pc, instr} = head;
  assign halted      = (state != F_RUN);

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLOCK_50),
    .rst   (reset),
    .flush (redirect_valid),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= F_RUN;
      fetch_pc    <= RESET_PC;
      req_pc      <= '0;
      inflight    <= 1'b0;
      req_live    <= 1'b0;
      req_epoch   <= 1'b0;
      epoch       <= 1'b0;
      fetch_count <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        req_pc    <= fetch_pc;
        req_epoch <= epoch;
        // Issued alongside an EOF response: already past end of program.
        req_live  <= !resp_eof;
      end

      if (redirect_valid) begin
        epoch    <= ~epoch;
        fetch_pc <= redirect_pc;
        state    <= F_RUN;
      end else begin
        if (issue)          fetch_pc <= fetch_pc + 32'd4;
        if (resp_eof)       state    <= F_HALT;
        else if (fault_enq) state    <= F_FAULT;
      end

      if (pop && (fetch_count != 32'hFFFF_FFFF))
        fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus randomized
// ready/redirect traffic, checked against an architectural stream model.
module tb_ifetch_queue;

  localparam int          DEPTH = 4;
  localparam int          WORDS = 35;
  localparam logic [31:0] EOFW  = 32'hFFFF_FFFF;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_index;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;
  logic        instr_fault;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halted;
  logic [31:0] fetch_count;

  ifetch_queue #(.DEPTH(DEPTH), .IMEM_WORDS(WORDS)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .imem_req(imem_req), .imem_index(imem_index), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_fault(instr_fault),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted), .fetch_count(fetch_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [31:0] mem [WORDS];

  // Synchronous-read instruction RAM.
  always @(posedge CLOCK_50)
    if (imem_req && imem_index < WORDS) imem_rdata <= mem[imem_index[5:0]];

  int n_chk = 0, n_err = 0;

  // Stream model: the core must see pc, pc+4, ... from the last restart
  // point, ending with the EOF word or one faulted EOF at a bad PC.
  logic [31:0] m_pc, m_cnt, last_idx;
  logic        m_done, last_req;
  int          stall;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_mem(input int eof_idx);
    for (int i = 0; i < WORDS; i++) begin
      mem[i] = $urandom;
      if (mem[i] == EOFW) mem[i] = 32'h0000_0013;
    end
    if (eof_idx < WORDS) mem[eof_idx] = EOFW;
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    reset = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #1;
    chk("rst_valid", instr_valid, 0);
    chk("rst_count", fetch_count, 0);
    chk("rst_halted", halted, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_fault", instr_fault, 0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    m_pc = '0; m_done = 1'b0; m_cnt = '0; stall = 0;
  endtask

  // One clock: drive inputs at the falling edge, check and update the model.
  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic        bad;
    logic [31:0] ei, wi;
    @(negedge CLOCK_50);
    instr_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    #1;
    chk("fetch_count", fetch_count, m_cnt);
    if (imem_req) chk("req_in_range", imem_index < WORDS, 1);
    if (m_done) begin
      chk("valid_after_end", instr_valid, 0);
      chk("halted_after_end", halted, 1);
      chk("req_after_end", imem_req, 0);
    end
    if (instr_valid && rdy) begin
      if (!m_done) begin
        bad = (m_pc >= WORDS * 4) || (m_pc[1:0] != 2'b00);
        wi  = m_pc >> 2;
        ei  = bad ? EOFW : mem[wi[5:0]];
        chk("pop_pc", instr_pc, m_pc);
        chk("pop_instr", instr, ei);
        chk("pop_fault", instr_fault, bad);
        m_done = (ei == EOFW);
        m_pc   = m_pc + 32'd4;
      end
      m_cnt = m_cnt + 32'd1;
      stall = 0;
    end else if (!m_done) begin
      stall++;
    end
    chk("progress", stall <= 40, 1);
    if (stall > 40) stall = 0;
    last_req = imem_req; last_idx = imem_index;
    if (rv) begin m_pc = rpc; m_done = 1'b0; stall = 0; end
  endtask

  initial begin
    bit found;
    logic rdy, rv;
    logic [31:0] rpc;

    // Short program, ready held high: fill latency and back-to-back delivery.
    fill_mem(99);
    mem[0] = 32'h0010_0093; mem[1] = 32'h0020_0113; mem[2] = 32'h0020_81B3; mem[3] = EOFW;
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      cyc(1, 0, 0);
      chk("t1_valid", instr_valid, (k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) chk("t1_pc", instr_pc, 32'((k - 2) * 4));
      chk("t1_halted", halted, (k >= 5));
    end
    chk("t1_count", fetch_count, 4);

    // Ready low: queue fills to DEPTH and fetching stops, then drains in order.
    fill_mem(99);
    do_reset();
    for (int k = 0; k < 10; k++) cyc(0, 0, 0);
    chk("t2_req_full", imem_req, 0);
    chk("t2_valid_full", instr_valid, 1);
    chk("t2_head_pc", instr_pc, 0);
    for (int k = 0; k < 8; k++) begin
      cyc(1, 0, 0);
      chk("t2_stream", instr_valid, 1);
    end

    // Redirect while the read for 0x10 is outstanding.
    fill_mem(99);
    do_reset();
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cyc(1, 0, 0);
      found = last_req && (last_idx == 32'd4);
    end
    chk("t3_reach_0x10", found, 1);
    cyc(1, 1, 32'h8);
    cyc(1, 0, 0);
    chk("t3_flushed", instr_valid, 0);
    chk("t3_req", imem_req, 1);
    chk("t3_index", imem_index, 2);
    for (int k = 0; k < 6; k++) cyc(1, 0, 0);

    // Halt on EOF at 0x10, then restart at 0x4.
    fill_mem(4);
    do_reset();
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      cyc(1, 0, 0);
      found = halted && !instr_valid;
    end
    chk("t4_halt_drain", found, 1);
    cyc(1, 1, 32'h4);
    chk("t4_halted_pre", halted, 1);
    cyc(1, 0, 0);
    chk("t4_halted_post", halted, 0);
    chk("t4_req", imem_req, 1);
    chk("t4_index", imem_index, 1);
    for (int k = 0; k < 8; k++) cyc(1, 0, 0);

    // Out-of-range and misaligned redirect targets.
    fill_mem(99);
    do_reset();
    for (int k = 0; k < 3; k++) cyc(1, 0, 0);
    for (int t = 0; t < 2; t++) begin
      rpc = (t == 0) ? 32'h100 : 32'h6;
      cyc(1, 1, rpc);
      cyc(1, 0, 0);
      chk("t5_no_req", imem_req, 0);
      chk("t5_empty", instr_valid, 0);
      cyc(0, 0, 0);
      chk("t5_valid", instr_valid, 1);
      chk("t5_halted", halted, 1);
      chk("t5_req_fault", imem_req, 0);
      chk("t5_fault", instr_fault, 1);
      chk("t5_pc", instr_pc, rpc);
      chk("t5_instr", instr, EOFW);
      for (int k = 0; k < 3; k++) cyc(1, 0, 0);
    end

    // Reset pulse mid-stream with entries queued and a read outstanding.
    fill_mem(99);
    do_reset();
    for (int k = 0; k < 6; k++) cyc(1, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0);
    chk("t6_pre_valid", instr_valid, 1);
    do_reset();
    cyc(1, 0, 0);
    chk("t6_no_stale", instr_valid, 0);
    cyc(1, 0, 0);
    chk("t6_restart_pc", instr_pc, 0);
    for (int k = 0; k < 6; k++) cyc(1, 0, 0);

    // Randomized ready and redirect traffic.
    for (int r = 0; r < 4; r++) begin
      fill_mem($urandom_range(0, 60));
      do_reset();
      for (int k = 0; k < 400; k++) begin
        rdy = ($urandom_range(0, 9) < 7);
        rv  = ($urandom_range(0, 99) < 4);
        case ($urandom_range(0, 9))
          7, 8:    rpc = {$urandom_range(0, WORDS - 1), 2'b00} | 32'($urandom_range(1, 3));
          9:       rpc = 32'h1000 + {$urandom_range(0, 255), 2'b00};
          default: rpc = {$urandom_range(0, WORDS + 2), 2'b00};
        endcase
        cyc(rdy, rv, rpc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
